ps2_key_tracker: RTL

//  Turns the PS/2 scancode byte stream into a live held-key bitmap for NUM_KEYS configurable keys, handling make, break (F0) and extended (E0) sequences.

---
 rtl/ps2_key_tracker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Decodes the PS/2 scancode byte stream (make, F0 break, E0 extended) into
//   a held-key bitmap for NUM_KEYS configurable keys. It also produces
//   single-cycle press/release pulses and reports the last accepted make code.
//   Optional feature: define PREFIX_TIMEOUT_EN to drop a pending E0/F0 prefix
//   when no follow-up byte arrives within TIMEOUT_CYCLES clocks.
//   The release pulse port is named release_pulse because "release" is a
//   reserved word in SystemVerilog.
module ps2_key_tracker #(
   parameter int                      NUM_KEYS       = 4,
   parameter logic [8*NUM_KEYS-1:0]   KEY_CODES      = {8'h75, 8'h72, 8'h29, 8'h1C},
   parameter logic [NUM_KEYS-1:0]     EXT_MASK       = 4'b1100,
   parameter int                      TIMEOUT_CYCLES = 50000000
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   input  logic                clr_all,
   output logic [NUM_KEYS-1:0] held,
   output logic [NUM_KEYS-1:0] press,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic                any_held,
   output logic [7:0]          last_code
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [NUM_KEYS-1:0] held_reg, held_next;
   logic [NUM_KEYS-1:0] press_reg, press_next;
   logic [NUM_KEYS-1:0] release_reg, release_next;
   logic                any_held_reg;
   logic [7:0]          last_code_reg, last_code_next;

   logic                do_make;
   logic                do_break;
   logic                ext_flag;
   logic                do_bat;
   logic                timeout_hit;
   logic [NUM_KEYS-1:0] key_match;

   // Per-key comparator: the byte and its E0 context must both agree with the key
   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_match
         assign key_match[gi] = (rx_data == KEY_CODES[8*gi +: 8]) &&
                                (ext_flag == EXT_MASK[gi]);
      end
   endgenerate

`ifdef PREFIX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt_reg;

   assign timeout_hit = (state_reg != ST_IDLE) && !rx_valid &&
                        (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   // Prefix watchdog: counts only while a prefix is pending and restarts on each byte
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cnt_reg <= '0;
      end else if (clr_all || rx_valid || (state_reg == ST_IDLE) || timeout_hit) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout_hit    = 1'b0;
`endif

   // Byte decoder: classifies the incoming byte and picks the next prefix state
   always_comb begin
      state_next = state_reg;
      do_make    = 1'b0;
      do_break   = 1'b0;
      ext_flag   = 1'b0;
      do_bat     = 1'b0;
      if (rx_valid) begin
         case (state_reg)
            ST_IDLE: begin
               case (rx_data)
                  8'hE0:                                    state_next = ST_EXT;
                  8'hF0:                                    state_next = ST_BRK;
                  8'hAA:                                    do_bat     = 1'b1;
                  8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF:        state_next = ST_IDLE;
                  default:                                  do_make    = 1'b1;
               endcase
            end
            ST_EXT: begin
               ext_flag = 1'b1;
               if (rx_data == 8'hF0) begin
                  state_next = ST_EXT_BRK;
               end else if (rx_data == 8'hE0) begin
                  state_next = ST_EXT;
               end else begin
                  do_make    = 1'b1;
                  state_next = ST_IDLE;
               end
            end
            ST_BRK: begin
               do_break   = 1'b1;
               state_next = ST_IDLE;
            end
            ST_EXT_BRK: begin
               ext_flag   = 1'b1;
               do_break   = 1'b1;
               state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end else if (timeout_hit) begin
         state_next = ST_IDLE;
      end
      if (clr_all) begin
         state_next = ST_IDLE;
      end
   end

   // Key bitmap update and edge pulses; clr_all overrides any byte in the same cycle
   always_comb begin
      held_next      = held_reg;
      last_code_next = last_code_reg;
      if (clr_all || do_bat) begin
         held_next = '0;
      end else begin
         if (do_make) begin
            held_next      = held_reg | key_match;
            last_code_next = rx_data;
         end
         if (do_break) begin
            held_next = held_reg & ~key_match;
         end
      end
      press_next   = held_next & ~held_reg;
      release_next = held_reg & ~held_next;
   end

   // Registered state and outputs
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         held_reg      <= '0;
         press_reg     <= '0;
         release_reg   <= '0;
         any_held_reg  <= 1'b0;
         last_code_reg <= 8'h00;
      end else begin
         state_reg     <= state_next;
         held_reg      <= held_next;
         press_reg     <= press_next;
         release_reg   <= release_next;
         any_held_reg  <= |held_next;
         last_code_reg <= last_code_next;
      end
   end

   assign held          = held_reg;
   assign press         = press_reg;
   assign release_pulse = release_reg;
   assign any_held      = any_held_reg;
   assign last_code     = last_code_reg;

endmodule
